axi_rd_sched: RTL and testbench

Read-request scheduler that shares one AXI read address/data channel pair between the CPU instruction and data SRAM-like read ports. It arbitrates pending reads, drives a single AR handshake, and tracks outstanding reads per requester. Read responses are routed back by ID. It stalls data reads that hit a write still in flight. It sits between the CPU SRAM-like interfaces and the AXI read channels, beside the write-path bridge, which supplies the pending-write address.

---
 rtl/axi_rd_sched_pkg.sv | 17 +
 rtl/axi_rd_sched_outs_counter.sv | 30 +++
 rtl/axi_rd_sched.sv | 135 +++++++++++++
 tb/tb_axi_rd_sched.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_sched_pkg.sv
// Shared types for the AXI read scheduler: requester IDs,
// FSM encoding and the SRAM-size to AXI-size mapping.
package axi_rd_sched_pkg;

    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_AR_HOLD = 1'b1
    } state_e;

    function automatic logic [2:0] to_arsize(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/axi_rd_sched_outs_counter.sv
// Outstanding-read counter for one requester ID.
// Saturates at zero on decrement and flags full at MAX_OUTS.
module outs_counter #(
    parameter int MAX_OUTS = 2
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic inc,
    input  logic dec,
    output logic full
);

    localparam int CW = $clog2(MAX_OUTS + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTS);

    logic [CW-1:0] cnt;

    assign full = (cnt >= MAX_C);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + CW'(1);
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/axi_rd_sched.sv
// Shares one AXI AR/R channel pair between the instruction and
// data read ports, with outstanding limits and a RAW hazard stall.
module axi_rd_sched
    import axi_rd_sched_pkg::*;
#(
    parameter int MAX_OUTS  = 2,
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    input  logic        wr_pend,
    input  logic [31:0] wr_addr,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    state_e state, state_nx;

    logic inst_full, data_full;
    logic hazard, inst_elig, data_elig, any_elig;
    logic pick_data, last_gnt, grant;
    logic ar_hs, r_hs;
    logic rq_v, rq_sel;
    logic unused_wr_lsb;

    assign unused_wr_lsb = ^wr_addr[1:0];

    // A data read to the word an in-flight write targets must wait.
    assign hazard    = wr_pend & (wr_addr[31:2] == data_addr[31:2]);
    assign inst_elig = inst_req & ~inst_full;
    assign data_elig = data_req & ~data_full & ~hazard;
    assign any_elig  = inst_elig | data_elig;

    always_comb begin
        pick_data = 1'b0;
        unique case (1'b1)
            (inst_elig & data_elig):  pick_data = DATA_PRIO ? 1'b1 : ~last_gnt;
            (data_elig & ~inst_elig): pick_data = 1'b1;
            default:                  pick_data = 1'b0;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (any_elig) state_nx = S_AR_HOLD;
            S_AR_HOLD: if (arready)  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        arvalid = (state == S_AR_HOLD);
        grant   = (state == S_IDLE) & any_elig;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arid     <= '0;
            araddr   <= '0;
            arsize   <= '0;
            last_gnt <= 1'b0;
        end else if (grant) begin
            arid     <= pick_data ? ID_DATA : ID_INST;
            araddr   <= pick_data ? data_addr : inst_addr;
            arsize   <= to_arsize(pick_data ? data_size : inst_size);
            last_gnt <= pick_data;
        end
    end

    assign ar_hs        = arvalid & arready;
    assign inst_addr_ok = ar_hs & (arid == ID_INST);
    assign data_addr_ok = ar_hs & (arid == ID_DATA);

    assign rready = aresetn;
    assign r_hs   = rvalid & rready;

    outs_counter #(.MAX_OUTS(MAX_OUTS)) u_inst_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .inc     (inst_addr_ok),
        .dec     (r_hs & rlast & (rid == ID_INST)),
        .full    (inst_full)
    );

    outs_counter #(.MAX_OUTS(MAX_OUTS)) u_data_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .inc     (data_addr_ok),
        .dec     (r_hs & rlast & (rid == ID_DATA)),
        .full    (data_full)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rq_v       <= 1'b0;
            rq_sel     <= 1'b0;
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            rq_v   <= r_hs;
            rq_sel <= rid[0];
            if (r_hs && !rid[0]) inst_rdata <= rdata;
            if (r_hs &&  rid[0]) data_rdata <= rdata;
        end
    end

    assign inst_data_ok = rq_v & ~rq_sel;
    assign data_data_ok = rq_v &  rq_sel;

endmodule

// File: tb/tb_axi_rd_sched.sv
// Self-checking bench for axi_rd_sched: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_axi_rd_sched;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        inst_req, data_req, wr_pend, arready, rlast, rvalid;
    logic [31:0] inst_addr, data_addr, wr_addr, rdata;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  rid;

    logic        inst_addr_ok1, inst_data_ok1, data_addr_ok1, data_data_ok1;
    logic        arvalid1, rready1;
    logic [31:0] inst_rdata1, data_rdata1, araddr1;
    logic [3:0]  arid1;
    logic [2:0]  arsize1;

    logic        inst_addr_ok0, inst_data_ok0, data_addr_ok0, data_data_ok0;
    logic        arvalid0, rready0;
    logic [31:0] inst_rdata0, data_rdata0, araddr0;
    logic [3:0]  arid0;
    logic [2:0]  arsize0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;

    axi_rd_sched #(.MAX_OUTS(2), .DATA_PRIO(1'b1)) u_dut_p1 (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok1), .inst_data_ok(inst_data_ok1),
        .inst_rdata(inst_rdata1),
        .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
        .data_addr_ok(data_addr_ok1), .data_data_ok(data_data_ok1),
        .data_rdata(data_rdata1),
        .wr_pend(wr_pend), .wr_addr(wr_addr),
        .arid(arid1), .araddr(araddr1), .arsize(arsize1),
        .arvalid(arvalid1), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast),
        .rvalid(rvalid), .rready(rready1)
    );

    axi_rd_sched #(.MAX_OUTS(2), .DATA_PRIO(1'b0)) u_dut_p0 (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok0), .inst_data_ok(inst_data_ok0),
        .inst_rdata(inst_rdata0),
        .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
        .data_addr_ok(data_addr_ok0), .data_data_ok(data_data_ok0),
        .data_rdata(data_rdata0),
        .wr_pend(wr_pend), .wr_addr(wr_addr),
        .arid(arid0), .araddr(araddr0), .arsize(arsize0),
        .arvalid(arvalid0), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast),
        .rvalid(rvalid), .rready(rready0)
    );

    task automatic idle_inputs();
        inst_req = 0; inst_addr = 0; inst_size = 0;
        data_req = 0; data_addr = 0; data_size = 0;
        wr_pend = 0; wr_addr = 0; arready = 0;
        rid = 0; rdata = 0; rlast = 0; rvalid = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        aresetn = 0;
        repeat (2) @(negedge aclk);
        aresetn = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        @(negedge aclk);
        aresetn = 0;
        inst_req = 1; data_req = 1; arready = 1;
        rvalid = 1; rlast = 1; rdata = 32'hFFFF_FFFF;
        #1;
        n_chk++;
        if ({arvalid1, arid1, araddr1, arsize1, inst_addr_ok1, data_addr_ok1,
             inst_data_ok1, data_data_ok1, inst_rdata1, data_rdata1, rready1} !== '0) begin
            n_fail++;
            $display("FAIL reset_p1: arvalid=%b arid=%h araddr=%h rready=%b want all 0",
                     arvalid1, arid1, araddr1, rready1);
        end
        n_chk++;
        if ({arvalid0, arid0, araddr0, arsize0, inst_addr_ok0, data_addr_ok0,
             inst_data_ok0, data_data_ok0, inst_rdata0, data_rdata0, rready0} !== '0) begin
            n_fail++;
            $display("FAIL reset_p0: arvalid=%b arid=%h araddr=%h rready=%b want all 0",
                     arvalid0, arid0, araddr0, rready0);
        end
        @(negedge aclk);
        idle_inputs();
        aresetn = 1;
    endtask

    task automatic test_inst_only();
        do_reset();
        inst_req = 1; inst_addr = 32'h1C00_0000; inst_size = 2; arready = 1;
        #1;
        n_chk++;
        if (arvalid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL inst_c0_arvalid: got %b want 0", arvalid1);
        end
        @(negedge aclk); #1;
        n_chk++;
        if ({arvalid1, arid1, araddr1, arsize1, inst_addr_ok1, data_addr_ok1}
            !== {1'b1, 4'd0, 32'h1C00_0000, 3'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL inst_c1_ar: got v=%b id=%h a=%h s=%h ok=%b/%b want 1 0 1c000000 2 1/0",
                     arvalid1, arid1, araddr1, arsize1, inst_addr_ok1, data_addr_ok1);
        end
        @(negedge aclk);
        inst_req = 0;
        #1;
        n_chk++;
        if ({arvalid1, inst_addr_ok1} !== 2'b00) begin
            n_fail++;
            $display("FAIL inst_c2_idle: got v=%b ok=%b want 0 0", arvalid1, inst_addr_ok1);
        end
        @(negedge aclk);
        rvalid = 1; rid = 0; rdata = 32'hDEAD_BEEF; rlast = 1;
        #1;
        n_chk++;
        if ({rready1, inst_data_ok1} !== 2'b10) begin
            n_fail++;
            $display("FAIL inst_r_cycle: got rready=%b dok=%b want 1 0", rready1, inst_data_ok1);
        end
        @(negedge aclk);
        rvalid = 0;
        #1;
        n_chk++;
        if ({inst_data_ok1, data_data_ok1, inst_rdata1} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL inst_data_ok: got %b/%b %h want 1/0 deadbeef",
                     inst_data_ok1, data_data_ok1, inst_rdata1);
        end
        @(negedge aclk); #1;
        n_chk++;
        if ({inst_data_ok1, inst_rdata1} !== {1'b0, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL inst_rdata_hold: got %b %h want 0 deadbeef", inst_data_ok1, inst_rdata1);
        end
    endtask

    task automatic test_tie();
        logic [7:0] seq0, seq1;
        int n0, n1;
        seq0 = 0; seq1 = 0; n0 = 0; n1 = 0;
        do_reset();
        inst_req = 1; inst_addr = 32'h1000; inst_size = 2;
        data_req = 1; data_addr = 32'h2000; data_size = 2;
        arready = 1;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (arvalid0) begin seq0 = {seq0[6:0], arid0[0]}; n0++; end
            if (arvalid1) begin seq1 = {seq1[6:0], arid1[0]}; n1++; end
            @(negedge aclk);
        end
        idle_inputs();
        n_chk++;
        if (n0 !== 4 || seq0 !== 8'b0000_1010) begin
            n_fail++;
            $display("FAIL tie_rr: got %0d grants seq %b want 4 seq 00001010", n0, seq0);
        end
        n_chk++;
        if (n1 !== 4 || seq1 !== 8'b0000_1100) begin
            n_fail++;
            $display("FAIL tie_prio: got %0d grants seq %b want 4 seq 00001100", n1, seq1);
        end
    endtask

    task automatic test_outs_limit();
        bit ev;
        logic [3:0] eid;
        do_reset();
        inst_req = 1; inst_addr = 32'h3000; inst_size = 2; arready = 1;
        for (int c = 0; c < 9; c++) begin
            if (c == 5) begin data_req = 1; data_addr = 32'h4000; data_size = 2; end
            if (c == 7) data_req = 0;
            #1;
            ev  = (c == 1 || c == 3 || c == 6);
            eid = (c == 6) ? 4'd1 : 4'd0;
            n_chk++;
            if (arvalid1 !== ev || (ev && arid1 !== eid)) begin
                n_fail++;
                $display("FAIL limit_c%0d: got v=%b id=%h want v=%b id=%h",
                         c, arvalid1, arid1, ev, eid);
            end
            @(negedge aclk);
        end
        rvalid = 1; rid = 0; rlast = 1; rdata = 32'h1234_5678;
        #1;
        n_chk++;
        if (arvalid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL limit_r_cycle: got v=%b want 0", arvalid1);
        end
        @(negedge aclk);
        rvalid = 0;
        #1;
        n_chk++;
        if (arvalid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL limit_release_idle: got v=%b want 0", arvalid1);
        end
        @(negedge aclk); #1;
        n_chk++;
        if ({arvalid1, arid1, araddr1} !== {1'b1, 4'd0, 32'h3000}) begin
            n_fail++;
            $display("FAIL limit_release: got v=%b id=%h a=%h want 1 0 3000",
                     arvalid1, arid1, araddr1);
        end
        @(negedge aclk);
        idle_inputs();
    endtask

    task automatic test_hazard();
        do_reset();
        wr_pend = 1; wr_addr = 32'h100;
        data_req = 1; data_addr = 32'h102; data_size = 1;
        inst_req = 1; inst_addr = 32'h200; inst_size = 2;
        arready = 1;
        @(negedge aclk); #1;
        n_chk++;
        if ({arvalid1, arid1, araddr1, inst_addr_ok1} !== {1'b1, 4'd0, 32'h200, 1'b1}) begin
            n_fail++;
            $display("FAIL hazard_inst_wins: got v=%b id=%h a=%h ok=%b want 1 0 200 1",
                     arvalid1, arid1, araddr1, inst_addr_ok1);
        end
        @(negedge aclk);
        inst_req = 0;
        for (int c = 2; c < 5; c++) begin
            if (c == 4) wr_pend = 0;
            #1;
            n_chk++;
            if (arvalid1 !== 1'b0) begin
                n_fail++;
                $display("FAIL hazard_block_c%0d: got v=%b want 0", c, arvalid1);
            end
            @(negedge aclk);
        end
        #1;
        n_chk++;
        if ({arvalid1, arid1, araddr1, arsize1, data_addr_ok1}
            !== {1'b1, 4'd1, 32'h102, 3'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL hazard_release: got v=%b id=%h a=%h s=%h ok=%b want 1 1 102 1 1",
                     arvalid1, arid1, araddr1, arsize1, data_addr_ok1);
        end
        @(negedge aclk);
        idle_inputs();
    endtask

    task automatic test_interleave();
        do_reset();
        inst_req = 1; inst_addr = 32'h500; inst_size = 2; arready = 1;
        repeat (3) @(negedge aclk);
        rvalid = 1; rid = 0; rlast = 1; rdata = 32'h1111_1111;
        #1;
        n_chk++;
        if ({arvalid1, inst_addr_ok1} !== 2'b11) begin
            n_fail++;
            $display("FAIL same_cycle_ar: got v=%b ok=%b want 1 1", arvalid1, inst_addr_ok1);
        end
        @(negedge aclk);
        rvalid = 0;
        #1;
        n_chk++;
        if ({inst_data_ok1, inst_rdata1} !== {1'b1, 32'h1111_1111}) begin
            n_fail++;
            $display("FAIL same_cycle_r: got %b %h want 1 11111111", inst_data_ok1, inst_rdata1);
        end
        @(negedge aclk); #1;
        n_chk++;
        if (arvalid1 !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_cnt_second: got v=%b want 1", arvalid1);
        end
        repeat (2) @(negedge aclk);
        #1;
        n_chk++;
        if (arvalid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_cnt_full: got v=%b want 0", arvalid1);
        end
        inst_req = 0;
        @(negedge aclk);
        rvalid = 1; rid = 1; rlast = 1; rdata = 32'hA5A5_A5A5;
        @(negedge aclk);
        rid = 0; rdata = 32'h5A5A_5A5A;
        #1;
        n_chk++;
        if ({data_data_ok1, inst_data_ok1, data_rdata1} !== {1'b1, 1'b0, 32'hA5A5_A5A5}) begin
            n_fail++;
            $display("FAIL ilv_data: got dok=%b iok=%b %h want 1 0 a5a5a5a5",
                     data_data_ok1, inst_data_ok1, data_rdata1);
        end
        @(negedge aclk);
        rvalid = 0;
        #1;
        n_chk++;
        if ({inst_data_ok1, data_data_ok1, inst_rdata1, data_rdata1}
            !== {1'b1, 1'b0, 32'h5A5A_5A5A, 32'hA5A5_A5A5}) begin
            n_fail++;
            $display("FAIL ilv_inst: got iok=%b dok=%b %h %h want 1 0 5a5a5a5a a5a5a5a5",
                     inst_data_ok1, data_data_ok1, inst_rdata1, data_rdata1);
        end
        @(negedge aclk);
        idle_inputs();
    endtask

    task automatic test_reset_hold();
        do_reset();
        inst_req = 1; inst_addr = 32'h600; inst_size = 2; arready = 1;
        repeat (4) @(negedge aclk);
        inst_req = 0;
        data_req = 1; data_addr = 32'h700; data_size = 2; arready = 0;
        @(negedge aclk); #1;
        n_chk++;
        if ({arvalid1, arid1, data_addr_ok1} !== {1'b1, 4'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL rsthold_pre: got v=%b id=%h ok=%b want 1 1 0",
                     arvalid1, arid1, data_addr_ok1);
        end
        #2;
        aresetn = 0;
        arready = 1;
        #1;
        n_chk++;
        if ({arvalid1, data_addr_ok1, inst_addr_ok1, araddr1} !== {3'b000, 32'h0}) begin
            n_fail++;
            $display("FAIL rsthold_clear: got v=%b ok=%b/%b a=%h want 0 0/0 0",
                     arvalid1, data_addr_ok1, inst_addr_ok1, araddr1);
        end
        @(negedge aclk);
        aresetn = 1;
        data_req = 0;
        inst_req = 1; inst_addr = 32'h800; inst_size = 2;
        @(negedge aclk); #1;
        n_chk++;
        if ({arvalid1, arid1, araddr1} !== {1'b1, 4'd0, 32'h800}) begin
            n_fail++;
            $display("FAIL rsthold_cnt_cleared: got v=%b id=%h a=%h want 1 0 800",
                     arvalid1, arid1, araddr1);
        end
        @(negedge aclk);
        idle_inputs();
    endtask

    task automatic test_random(input bit prio, input int ncyc);
        int          cnt[2];
        bit          pv, last_d, rqv, rqs, acc_i, acc_d;
        bit          ei, ed, pick_d, e_iok, e_dok;
        bit          inc_i, inc_d, dec_i, dec_d;
        logic [3:0]  pid;
        logic [31:0] paddr;
        logic [2:0]  psz;
        logic [31:0] bufm[2];
        logic        a_v, a_iok, a_dok, a_idok, a_ddok, a_rr;
        logic [3:0]  a_id;
        logic [31:0] a_addr, a_ird, a_drd;
        logic [2:0]  a_sz;
        cnt[0] = 0; cnt[1] = 0; bufm[0] = 0; bufm[1] = 0;
        pv = 0; last_d = 0; rqv = 0; rqs = 0; acc_i = 0; acc_d = 0;
        pid = 0; paddr = 0; psz = 0;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            if (acc_i) inst_req = 0;
            if (!inst_req && $urandom_range(1, 0) == 1) begin
                inst_req = 1; inst_addr = $urandom; inst_size = 2'($urandom_range(2, 0));
            end
            if (acc_d) data_req = 0;
            if (!data_req && $urandom_range(1, 0) == 1) begin
                data_req = 1; data_addr = {24'h0, 8'($urandom)};
                data_size = 2'($urandom_range(2, 0));
            end
            wr_pend = ($urandom_range(2, 0) == 0);
            wr_addr = ($urandom_range(1, 0) == 1) ? (data_addr ^ {30'h0, 2'($urandom)})
                                                  : {24'h0, 8'($urandom)};
            arready = ($urandom_range(3, 0) != 0);
            rvalid  = ($urandom_range(3, 0) == 0);
            rlast   = ($urandom_range(7, 0) != 0);
            rdata   = $urandom;
            if (cnt[0] > 0 && cnt[1] > 0) rid = {3'b0, 1'($urandom)};
            else if (cnt[0] > 0)          rid = 4'd0;
            else if (cnt[1] > 0)          rid = 4'd1;
            else                          rid = {3'b0, 1'($urandom)};
            #1;
            a_v   = prio ? arvalid1 : arvalid0;
            a_id  = prio ? arid1 : arid0;
            a_addr = prio ? araddr1 : araddr0;
            a_sz  = prio ? arsize1 : arsize0;
            a_iok = prio ? inst_addr_ok1 : inst_addr_ok0;
            a_dok = prio ? data_addr_ok1 : data_addr_ok0;
            a_idok = prio ? inst_data_ok1 : inst_data_ok0;
            a_ddok = prio ? data_data_ok1 : data_data_ok0;
            a_ird = prio ? inst_rdata1 : inst_rdata0;
            a_drd = prio ? data_rdata1 : data_rdata0;
            a_rr  = prio ? rready1 : rready0;
            e_iok = pv && arready && pid == 4'd0;
            e_dok = pv && arready && pid == 4'd1;
            n_chk++;
            if (a_v !== pv || a_rr !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd_arvalid p%0d c%0d: got v=%b rr=%b want v=%b rr=1",
                         prio, c, a_v, a_rr, pv);
            end
            if (pv) begin
                n_chk++;
                if ({a_id, a_addr, a_sz} !== {pid, paddr, psz}) begin
                    n_fail++;
                    $display("FAIL rnd_payload p%0d c%0d: got %h %h %h want %h %h %h",
                             prio, c, a_id, a_addr, a_sz, pid, paddr, psz);
                end
            end
            n_chk++;
            if ({a_iok, a_dok} !== {e_iok, e_dok}) begin
                n_fail++;
                $display("FAIL rnd_addr_ok p%0d c%0d: got %b%b want %b%b",
                         prio, c, a_iok, a_dok, e_iok, e_dok);
            end
            n_chk++;
            if ({a_idok, a_ddok, a_ird, a_drd} !== {rqv && !rqs, rqv && rqs, bufm[0], bufm[1]}) begin
                n_fail++;
                $display("FAIL rnd_rdata p%0d c%0d: got %b%b %h %h want %b%b %h %h",
                         prio, c, a_idok, a_ddok, a_ird, a_drd,
                         rqv && !rqs, rqv && rqs, bufm[0], bufm[1]);
            end
            inc_i = e_iok;
            inc_d = e_dok;
            dec_i = rvalid && rlast && rid == 4'd0;
            dec_d = rvalid && rlast && rid == 4'd1;
            if (pv) begin
                if (arready) pv = 0;
            end else begin
                ei = inst_req && cnt[0] < 2;
                ed = data_req && cnt[1] < 2 && !(wr_pend && wr_addr[31:2] == data_addr[31:2]);
                if (ei || ed) begin
                    pick_d = (ei && ed) ? (prio ? 1'b1 : !last_d) : ed;
                    pv     = 1;
                    pid    = pick_d ? 4'd1 : 4'd0;
                    paddr  = pick_d ? data_addr : inst_addr;
                    psz    = {1'b0, pick_d ? data_size : inst_size};
                    last_d = pick_d;
                end
            end
            cnt[0] = cnt[0] + int'(inc_i) - int'(dec_i);
            cnt[1] = cnt[1] + int'(inc_d) - int'(dec_d);
            if (cnt[0] < 0) cnt[0] = 0;
            if (cnt[1] < 0) cnt[1] = 0;
            rqv = rvalid;
            rqs = rid[0];
            if (rvalid) bufm[rid[0]] = rdata;
            acc_i = e_iok;
            acc_d = e_dok;
            @(negedge aclk);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        aresetn = 0;
        test_reset();
        test_inst_only();
        test_tie();
        test_outs_limit();
        test_hazard();
        test_interleave();
        test_reset_hold();
        test_random(1'b1, 1500);
        test_random(1'b0, 1500);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
